// File: rtl/board_renderer.sv
// board_renderer: repaints Plot Four squares whose blue/red occupancy changed into the vga_adapter frame buffer.
// Latency: 1 scan cycle + FILL*FILL plot cycles per stale square; all outputs registered, no backpressure (one pixel per clk).
// Optional BOARD_RENDER_GRID_EN: paints a green background under every cell once after reset.
module board_renderer #(
    parameter int X0   = 40,
    parameter int Y0   = 10,
    parameter int CELL = 20,
    parameter int FILL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] blue,
    input  logic [19:0] red,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy
);
    localparam int PW  = (FILL > 1) ? $clog2(FILL) : 1;
    localparam int OFS = (CELL - FILL) / 2;
    localparam logic [PW-1:0] PMAX = PW'(FILL - 1);
    localparam logic [4:0]    LAST = 5'd19;

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, GRID} state_t;

    state_t        state, state_n;
    logic [4:0]    idx, idx_n;
    logic [PW-1:0] px, px_n, py, py_n;
    logic          lat_b, lat_b_n, lat_r, lat_r_n;
    logic [2:0]    lat_col, lat_col_n;
    logic [19:0]   drawn_b, drawn_r, valid, stale;
    logic          commit;
    logic [7:0]    x_n;
    logic [6:0]    y_n;
    logic [2:0]    colour_n;
    logic          plot_n, busy_n;

`ifdef BOARD_RENDER_GRID_EN
    localparam logic [7:0] GX_MAX = 8'(4 * CELL - 1);
    localparam logic [6:0] GY_MAX = 7'(5 * CELL - 1);
    logic [7:0] gx, gx_n;
    logic [6:0] gy, gy_n;
    logic       grid_done, grid_done_n;
`endif

    function automatic logic [2:0] square_colour(input logic b, input logic r);
        case ({b, r})
            2'b00:   square_colour = 3'b111;
            2'b10:   square_colour = 3'b001;
            2'b01:   square_colour = 3'b100;
            default: square_colour = 3'b101;
        endcase
    endfunction

    // A square never drawn since reset is stale regardless of its occupancy.
    assign stale = ~valid | (blue ^ drawn_b) | (red ^ drawn_r);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        px_n      = px;
        py_n      = py;
        lat_b_n   = lat_b;
        lat_r_n   = lat_r;
        lat_col_n = lat_col;
        commit    = 1'b0;
`ifdef BOARD_RENDER_GRID_EN
        gx_n        = gx;
        gy_n        = gy;
        grid_done_n = grid_done;
`endif
        case (state)
            IDLE: begin
`ifdef BOARD_RENDER_GRID_EN
                if (!grid_done) begin
                    state_n = GRID;
                    gx_n    = '0;
                    gy_n    = '0;
                end else
`endif
                if (|stale) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                if (stale[idx]) begin
                    lat_b_n   = blue[idx];
                    lat_r_n   = red[idx];
                    lat_col_n = square_colour(blue[idx], red[idx]);
                    px_n      = '0;
                    py_n      = '0;
                    state_n   = DRAW;
                end else if (idx == LAST) begin
                    state_n = IDLE;
                end else begin
                    idx_n = idx + 5'd1;
                end
            end
            DRAW: begin
                if (px == PMAX) begin
                    px_n = '0;
                    if (py == PMAX) begin
                        commit = 1'b1;
                        py_n   = '0;
                        if (idx == LAST) begin
                            state_n = IDLE;
                        end else begin
                            state_n = SCAN;
                            idx_n   = idx + 5'd1;
                        end
                    end else begin
                        py_n = py + 1'b1;
                    end
                end else begin
                    px_n = px + 1'b1;
                end
            end
`ifdef BOARD_RENDER_GRID_EN
            GRID: begin
                if (gx == GX_MAX) begin
                    gx_n = '0;
                    if (gy == GY_MAX) begin
                        grid_done_n = 1'b1;
                        state_n     = SCAN;
                        idx_n       = '0;
                    end else begin
                        gy_n = gy + 7'd1;
                    end
                end else begin
                    gx_n = gx + 8'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so the registered pixel lines up with the DRAW cycle.
    always_comb begin
        x_n      = x;
        y_n      = y;
        colour_n = colour;
        plot_n   = 1'b0;
        busy_n   = (state_n != IDLE);
        if (state_n == DRAW) begin
            x_n      = 8'(X0 + OFS + CELL * int'(idx_n[1:0]) + int'(px_n));
            y_n      = 7'(Y0 + OFS + CELL * int'(idx_n[4:2]) + int'(py_n));
            colour_n = lat_col_n;
            plot_n   = 1'b1;
        end
`ifdef BOARD_RENDER_GRID_EN
        else if (state_n == GRID) begin
            x_n      = 8'(X0 + int'(gx_n));
            y_n      = 7'(Y0 + int'(gy_n));
            colour_n = 3'b010;
            plot_n   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            px      <= '0;
            py      <= '0;
            lat_b   <= 1'b0;
            lat_r   <= 1'b0;
            lat_col <= '0;
            drawn_b <= '0;
            drawn_r <= '0;
            valid   <= '0;
`ifdef BOARD_RENDER_GRID_EN
            gx        <= '0;
            gy        <= '0;
            grid_done <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            px      <= px_n;
            py      <= py_n;
            lat_b   <= lat_b_n;
            lat_r   <= lat_r_n;
            lat_col <= lat_col_n;
            if (commit) begin
                drawn_b[idx] <= lat_b;
                drawn_r[idx] <= lat_r;
                valid[idx]   <= 1'b1;
            end
`ifdef BOARD_RENDER_GRID_EN
            gx        <= gx_n;
            gy        <= gy_n;
            grid_done <= grid_done_n;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            x      <= x_n;
            y      <= y_n;
            colour <= colour_n;
            plot   <= plot_n;
            busy   <= busy_n;
        end
    end
endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: logs every plotted pixel, replays it into a model frame buffer and
// compares against the picture implied by the current blue/red inputs.
module tb_board_renderer;
    localparam int X0 = 40, Y0 = 10, CELL = 20, FILL = 16, OFS = (CELL - FILL) / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] blue = '0;
    logic [19:0] red = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy;

    board_renderer dut (
        .clk(clk), .reset(reset), .blue(blue), .red(red),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    pix_t log_q[$];

    always @(negedge clk) begin
        if (plot === 1'b1) log_q.push_back('{int'(x), int'(y), int'(colour)});
    end

    int checks = 0;
    int errors = 0;
    int replayed = 0;
    logic [2:0] fb [0:159][0:119];

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] sq_col(input logic b, input logic r);
        if (!b && !r) return 3'b111;
        if (b && !r)  return 3'b001;
        if (!b && r)  return 3'b100;
        return 3'b101;
    endfunction

    // Which square's filled area (if any) covers pixel (px,py).
    function automatic int sq_at(input int px, input int py);
        int c, r, ox, oy;
        if (px < X0 || py < Y0) return -1;
        c  = (px - X0) / CELL;
        r  = (py - Y0) / CELL;
        ox = (px - X0) % CELL;
        oy = (py - Y0) % CELL;
        if (c > 3 || r > 4) return -1;
        if (ox < OFS || ox >= OFS + FILL || oy < OFS || oy >= OFS + FILL) return -1;
        return r * 4 + c;
    endfunction

    function automatic int count_seg(input int s, input int e, input int sq, input int c);
        int n = 0;
        for (int k = s; k < e && k < log_q.size(); k++)
            if (sq_at(log_q[k].x, log_q[k].y) == sq && log_q[k].c == c) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_quiet(output int cyc);
        int q;
        q = 0;
        cyc = 0;
        while (q < 3 && cyc < 12000) begin
            tick();
            cyc++;
            if (busy === 1'b0) q++; else q = 0;
        end
        chk("quiesce_in_time", int'(cyc < 12000), 1);
    endtask

    task automatic check_frame(input string tag);
        int bad, sq;
        logic [2:0] e;
        while (replayed < log_q.size()) begin
            if (log_q[replayed].x < 160 && log_q[replayed].y < 120)
                fb[log_q[replayed].x][log_q[replayed].y] = 3'(log_q[replayed].c);
            replayed++;
        end
        bad = 0;
        for (int xx = 0; xx < 160; xx++) begin
            for (int yy = 0; yy < 120; yy++) begin
                sq = sq_at(xx, yy);
                e  = (sq < 0) ? 3'b000 : sq_col(blue[sq], red[sq]);
                if (fb[xx][yy] !== e) bad++;
            end
        end
        chk(tag, bad, 0);
    endtask

    task automatic full_repaint_after_release(input string tag);
        int cyc, s;
        s   = log_q.size();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy === 1'b1 && cyc < 6000);
        chk({tag, "_busy_cycles"}, cyc, 5141);
        chk({tag, "_plots"}, log_q.size() - s, 5120);
    endtask

    initial begin
        int cyc, s, lat, n, sq, v, expn, mnx, mxx, mny, mxy;
        logic [19:0] pb, pr;
        for (int xx = 0; xx < 160; xx++)
            for (int yy = 0; yy < 120; yy++) fb[xx][yy] = 3'b000;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);

        // Full repaint of an empty board
        s = log_q.size();
        reset = 1'b0;
        full_repaint_after_release("init");
        if (log_q.size() > s) begin
            chk("init_first_x", log_q[s].x, 42);
            chk("init_first_y", log_q[s].y, 12);
            chk("init_last_x", log_q[log_q.size()-1].x, 117);
            chk("init_last_y", log_q[log_q.size()-1].y, 107);
        end
        n = 0;
        for (int k = s; k < log_q.size(); k++) if (log_q[k].c == 7) n++;
        chk("init_all_white", n, 5120);
        pb = blue; pr = red;
        check_frame("init_frame");

        // Single blue square
        s = log_q.size();
        blue[5] = 1'b1;
        lat = 0;
        while (log_q.size() == s && lat < 40) begin
            tick();
            lat++;
        end
        chk("sq5_latency_ok", int'(lat <= 7), 1);
        wait_quiet(cyc);
        chk("sq5_plots", log_q.size() - s, 256);
        chk("sq5_blue_count", count_seg(s, log_q.size(), 5, 1), 256);
        mnx = 999; mxx = -1; mny = 999; mxy = -1;
        for (int k = s; k < log_q.size(); k++) begin
            if (log_q[k].x < mnx) mnx = log_q[k].x;
            if (log_q[k].x > mxx) mxx = log_q[k].x;
            if (log_q[k].y < mny) mny = log_q[k].y;
            if (log_q[k].y > mxy) mxy = log_q[k].y;
        end
        chk("sq5_xmin", mnx, 62);
        chk("sq5_xmax", mxx, 77);
        chk("sq5_ymin", mny, 32);
        chk("sq5_ymax", mxy, 47);
        check_frame("sq5_frame");

        // Illegal both-players marker
        s = log_q.size();
        blue[7] = 1'b1;
        red[7]  = 1'b1;
        wait_quiet(cyc);
        chk("sq7_plots", log_q.size() - s, 256);
        chk("sq7_magenta", count_seg(s, log_q.size(), 7, 5), 256);
        check_frame("sq7_frame");

        // Inputs change while square 2 is being drawn
        s = log_q.size();
        blue[2] = 1'b1;
        lat = 0;
        while (log_q.size() == s && lat < 40) begin
            tick();
            lat++;
        end
        repeat (50) tick();
        red[19] = 1'b1;
        red[2]  = 1'b1;
        wait_quiet(cyc);
        chk("mid_plots", log_q.size() - s, 768);
        chk("mid_sq2_latched_blue", count_seg(s, s + 256, 2, 1), 256);
        chk("mid_sq19_red", count_seg(s + 256, s + 512, 19, 4), 256);
        chk("mid_sq2_magenta", count_seg(s + 512, s + 768, 2, 5), 256);
        check_frame("mid_frame");
        pb = blue; pr = red;

        // Random occupancy changes against the scoreboard
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                sq = $urandom_range(0, 19);
                v  = $urandom_range(0, 3);
                blue[sq] = v[1];
                red[sq]  = v[0];
            end
            expn = 0;
            for (int i = 0; i < 20; i++)
                if (blue[i] != pb[i] || red[i] != pr[i]) expn += 256;
            s = log_q.size();
            wait_quiet(cyc);
            chk("rand_plots", log_q.size() - s, expn);
            check_frame("rand_frame");
            pb = blue; pr = red;
        end

        // Reset in the middle of drawing square 3
        s = log_q.size();
        blue[3] = ~pb[3];
        lat = 0;
        while (log_q.size() - s < 100 && lat < 400) begin
            tick();
            lat++;
        end
        chk("mid_rst_plots_before", log_q.size() - s, 100);
        reset = 1'b1;
        #1;
        chk("mid_rst_plot_low", int'(plot), 0);
        chk("mid_rst_busy_low", int'(busy), 0);
        repeat (2) tick();
        reset = 1'b0;
        full_repaint_after_release("rerun");
        check_frame("rerun_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
